// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the pulse-drained FIFO.
// Pointer and count widths both carry one extra wrap bit above the address.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FIFO_DEF_DEPTH = 8;

  typedef logic [ptr_w(FIFO_DEF_DEPTH)-1:0] ptr_t;
  typedef logic [ptr_w(FIFO_DEF_DEPTH)-1:0] cnt_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, combinational read.
// Contents are never reset; the pointer logic decides what is valid.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pulse_fifo.sv
// FIFO drained by single-cycle pop pulses; popped word appears registered one cycle later.
// hold_o flags near-empty so the upstream pulse generator stops requesting.
module pulse_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int LOW_WATER = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_valid_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  output logic                   wr_ready_o,
  input  logic                   pop_pulse_i,
  output logic                   rd_valid_o,
  output logic [DATA_W-1:0]      rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   hold_o,
  output logic                   underflow_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d, hold_q, hold_d;
  logic              rd_valid_q, rd_valid_d, underflow_q, underflow_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, mem_rdata;
  logic              push, pop;

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // Pop qualifies on the registered empty flag, so an empty-cycle push never falls through.
  always_comb begin
    push        = wr_valid_i && !full_q;
    pop         = pop_pulse_i && !empty_q;
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    count_d     = wr_ptr_d - rd_ptr_d;
    empty_d     = (wr_ptr_d == rd_ptr_d);
    full_d      = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    hold_d      = (count_d <= PW'(LOW_WATER));
    rd_valid_d  = pop;
    rd_data_d   = pop ? mem_rdata : rd_data_q;
    underflow_d = underflow_q || (pop_pulse_i && empty_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      hold_q      <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      hold_q      <= hold_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_ready_o  = !full_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign count_o     = count_q;
  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign hold_o      = hold_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_pulse_fifo.sv
// Bench for pulse_fifo: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_pulse_fifo;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 8;
  localparam int LOW_WATER = 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              wr_valid_i = 1'b0;
  logic [DATA_W-1:0] wr_data_i = '0;
  logic              pop_pulse_i = 1'b0;
  logic              wr_ready_o, rd_valid_o, empty_o, full_o, hold_o, underflow_o;
  logic [DATA_W-1:0] rd_data_o;
  logic [$clog2(DEPTH):0] count_o;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] mq[$];
  logic              m_rdv = 1'b0;
  logic [DATA_W-1:0] m_rdd = '0;
  logic              m_unf = 1'b0;

  always #5 clk_i = ~clk_i;

  pulse_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_valid_i  (wr_valid_i),
    .wr_data_i   (wr_data_i),
    .wr_ready_o  (wr_ready_o),
    .pop_pulse_i (pop_pulse_i),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .count_o     (count_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .hold_o      (hold_o),
    .underflow_o (underflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Occupancy rules applied to a plain queue, using pre-edge occupancy.
  task automatic model_edge(input logic wv, input logic [DATA_W-1:0] wd,
                            input logic pp, input logic rs);
    int n;
    if (rs) begin
      mq.delete();
      m_rdv = 1'b0;
      m_rdd = '0;
      m_unf = 1'b0;
      return;
    end
    n = mq.size();
    m_rdv = 1'b0;
    if (pp && n == 0) m_unf = 1'b1;
    if (pp && n > 0) begin
      m_rdd = mq.pop_front();
      m_rdv = 1'b1;
    end
    if (wv && n < DEPTH) mq.push_back(wd);
  endtask

  task automatic cyc(input logic wv, input logic [DATA_W-1:0] wd,
                     input logic pp, input logic rs);
    int n;
    wr_valid_i  = wv;
    wr_data_i   = wd;
    pop_pulse_i = pp;
    rst_i       = rs;
    @(posedge clk_i);
    model_edge(wv, wd, pp, rs);
    #1;
    n = mq.size();
    chk("count",     32'(count_o),     32'(n));
    chk("empty",     32'(empty_o),     32'(n == 0));
    chk("full",      32'(full_o),      32'(n == DEPTH));
    chk("wr_ready",  32'(wr_ready_o),  32'(n != DEPTH));
    chk("hold",      32'(hold_o),      32'(n <= LOW_WATER));
    chk("rd_valid",  32'(rd_valid_o),  32'(m_rdv));
    chk("rd_data",   32'(rd_data_o),   32'(m_rdd));
    chk("underflow", 32'(underflow_o), 32'(m_unf));
    wr_valid_i  = 1'b0;
    pop_pulse_i = 1'b0;
    rst_i       = 1'b0;
  endtask

  initial begin
    int pw, pp;
    // reset
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_hold",  32'(hold_o), 1);

    // ordering
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(0, 0, 1, 0);
    chk("ord_d0", 32'(rd_data_o), 32'h11);
    cyc(0, 0, 1, 0);
    chk("ord_d1", 32'(rd_data_o), 32'h22);
    cyc(0, 0, 1, 0);
    chk("ord_d2", 32'(rd_data_o), 32'h33);
    chk("ord_empty", 32'(empty_o), 1);
    cyc(0, 0, 0, 0);
    chk("ord_strobe_end", 32'(rd_valid_o), 0);

    // full and dropped 9th push
    for (int i = 0; i < DEPTH; i++) cyc(1, DATA_W'(8'hA0 + i), 0, 0);
    chk("full_flag", 32'(full_o), 1);
    chk("full_ready", 32'(wr_ready_o), 0);
    cyc(1, 8'h99, 0, 0);
    cyc(0, 0, 1, 0);
    chk("full_cnt7", 32'(count_o), 7);
    chk("full_first", 32'(rd_data_o), 32'hA0);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 0, 1, 0);
    chk("full_last", 32'(rd_data_o), 32'hA7);
    chk("full_drained", 32'(empty_o), 1);

    // full + push + pop: push rejected
    for (int i = 0; i < DEPTH; i++) cyc(1, DATA_W'(8'hC0 + i), 0, 0);
    cyc(1, 8'h5A, 1, 0);
    chk("fullpp_cnt", 32'(count_o), DEPTH - 1);
    cyc(0, 0, 0, 1);

    // wrap with simultaneous push/pop
    for (int i = 0; i < 4; i++) cyc(1, DATA_W'(8'h40 + i), 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, DATA_W'(8'h50 + i), 1, 0);
    chk("wrap_cnt", 32'(count_o), 4);
    chk("wrap_last", 32'(rd_data_o), 32'h57);

    // underflow with simultaneous push
    cyc(0, 0, 0, 1);
    cyc(1, 8'hAA, 1, 0);
    chk("unf_flag", 32'(underflow_o), 1);
    chk("unf_cnt", 32'(count_o), 1);
    chk("unf_rdv", 32'(rd_valid_o), 0);
    cyc(0, 0, 1, 0);
    chk("unf_data", 32'(rd_data_o), 32'hAA);
    cyc(0, 0, 1, 0);
    chk("unf_keep", 32'(rd_data_o), 32'hAA);

    // hold rises at LOW_WATER, then reset mid-pop
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, DATA_W'(8'h70 + i), 0, 0);
    chk("hold_lo3", 32'(hold_o), 0);
    cyc(0, 0, 1, 0);
    chk("hold_lo2", 32'(hold_o), 0);
    cyc(0, 0, 1, 0);
    chk("hold_hi1", 32'(hold_o), 1);
    cyc(1, 8'h7F, 0, 0);
    cyc(1, 8'h7E, 1, 1);
    chk("rst_mid_cnt", 32'(count_o), 0);
    chk("rst_mid_rdv", 32'(rd_valid_o), 0);
    chk("rst_mid_rdd", 32'(rd_data_o), 0);

    // random traffic with shifting push/pop bias
    for (int blk = 0; blk < 6; blk++) begin
      pw = (blk % 3 == 0) ? 80 : (blk % 3 == 1) ? 30 : 55;
      pp = (blk % 3 == 0) ? 30 : (blk % 3 == 1) ? 80 : 50;
      for (int i = 0; i < 100; i++) begin
        cyc(logic'($urandom_range(99) < pw), DATA_W'($urandom),
            logic'($urandom_range(99) < pp), logic'($urandom_range(199) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
